// File: rtl/frame_sequencer.sv
// frame_sequencer: double-buffered 8x8 frame store for the charlieplex scanner.
// The host fills the back buffer row by row, then commits. The swap to the
// front buffer waits for a scan-frame boundary and a minimum hold count, so
// the scanner never shows a torn image and animation pacing is enforced.
module frame_sequencer #(
    parameter logic [5:0] FRAME_DONE_INDEX = 6'd63,
    parameter int         HOLD_W           = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [2:0]        wr_row,
    input  logic [7:0]        wr_data,
    input  logic              commit_valid,
    output logic              commit_ready,
    input  logic [HOLD_W-1:0] hold_frames,
    input  logic              blank,
    input  logic              is_frame_done,
    output logic [63:0]       memory_frame_buffer,
    output logic [5:0]        frame_done_index,
    output logic              swap_pulse,
    output logic              busy
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [63:0]         buf_a_q, buf_a_d;
    logic [63:0]         buf_b_q, buf_b_d;
    logic                front_sel_q, front_sel_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                blank_q;
    logic                swap_pulse_q;
    logic                swap;
    logic                wr_acc;
    logic [5:0]          row_base;

    assign row_base = {wr_row, 3'b000};
    assign wr_acc   = wr_valid & wr_ready;

    // Control FSM: handshake readiness decoded from state, swap decision in PENDING.
    always_comb begin
        state_d      = state_q;
        wr_ready     = 1'b0;
        commit_ready = 1'b0;
        busy         = 1'b0;
        swap         = 1'b0;
        case (state_q)
            IDLE: begin
                wr_ready     = 1'b1;
                commit_ready = 1'b1;
                if (commit_valid) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                busy = 1'b1;
                if (is_frame_done && (hold_cnt_q >= hold_frames)) begin
                    swap    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer, selector and hold-counter next state; writes always land in the back buffer.
    always_comb begin
        buf_a_d     = buf_a_q;
        buf_b_d     = buf_b_q;
        front_sel_d = front_sel_q ^ swap;
        hold_cnt_d  = hold_cnt_q;
        if (wr_acc) begin
            if (front_sel_q) begin
                buf_a_d[row_base +: 8] = wr_data;
            end else begin
                buf_b_d[row_base +: 8] = wr_data;
            end
        end
        if (swap) begin
            hold_cnt_d = '0;
        end else if (is_frame_done && (hold_cnt_q != {HOLD_W{1'b1}})) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    // State registers; reset clears both buffers so a pending commit is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            buf_a_q      <= '0;
            buf_b_q      <= '0;
            front_sel_q  <= 1'b0;
            hold_cnt_q   <= '0;
            blank_q      <= 1'b0;
            swap_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_a_q      <= buf_a_d;
            buf_b_q      <= buf_b_d;
            front_sel_q  <= front_sel_d;
            hold_cnt_q   <= hold_cnt_d;
            blank_q      <= blank;
            swap_pulse_q <= swap;
        end
    end

    assign memory_frame_buffer = blank_q ? 64'd0 : (front_sel_q ? buf_b_q : buf_a_q);
    assign frame_done_index    = FRAME_DONE_INDEX;
    assign swap_pulse          = swap_pulse_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: image-level reference model (front/back images,
// pending flag, hold count) advanced once per clock, compared inline per test.
module tb_frame_sequencer;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_row;
    logic [7:0]  wr_data;
    logic        commit_valid;
    logic        commit_ready;
    logic [3:0]  hold_frames;
    logic        blank;
    logic        is_frame_done;
    logic [63:0] memory_frame_buffer;
    logic [5:0]  frame_done_index;
    logic        swap_pulse;
    logic        busy;

    frame_sequencer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .wr_valid            (wr_valid),
        .wr_ready            (wr_ready),
        .wr_row              (wr_row),
        .wr_data             (wr_data),
        .commit_valid        (commit_valid),
        .commit_ready        (commit_ready),
        .hold_frames         (hold_frames),
        .blank               (blank),
        .is_frame_done       (is_frame_done),
        .memory_frame_buffer (memory_frame_buffer),
        .frame_done_index    (frame_done_index),
        .swap_pulse          (swap_pulse),
        .busy                (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: what is shown, what is being prepared, and pacing state.
    logic [63:0] m_front, m_back;
    logic        m_pend, m_swap, m_blank;
    int          m_hold;
    int          phase;
    logic        last_fd;

    function automatic logic [63:0] m_out();
        return m_blank ? 64'd0 : m_front;
    endfunction

    task automatic model_clear();
        m_front = '0; m_back = '0; m_pend = 0; m_swap = 0; m_blank = 0; m_hold = 0;
    endtask

    // One clock: model sees the same inputs as the DUT, then strobe for next cycle.
    task automatic tick();
        logic        wacc, cacc, swp;
        logic [63:0] tmp;
        @(posedge clk);
        last_fd = is_frame_done;
        if (rst_n) begin
            wacc = wr_valid && !m_pend;
            cacc = commit_valid && !m_pend;
            swp  = m_pend && is_frame_done && (m_hold >= int'(hold_frames));
            if (wacc) m_back[int'(wr_row)*8 +: 8] = wr_data;
            if (swp) begin
                tmp = m_front; m_front = m_back; m_back = tmp;
                m_hold = 0; m_pend = 0;
            end else if (is_frame_done && m_hold < 15) begin
                m_hold++;
            end
            if (cacc) m_pend = 1;
            m_swap  = swp;
            m_blank = blank;
        end
        #1;
        phase = (phase + 1) % 64;
        is_frame_done = (phase == 63);
    endtask

    task automatic write_row(input logic [2:0] r, input logic [7:0] d);
        wr_valid = 1; wr_row = r; wr_data = d;
        tick();
        wr_valid = 0;
    endtask

    task automatic commit();
        commit_valid = 1;
        tick();
        commit_valid = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #3;
        model_clear();
        tick(); tick();
        checks++; if (memory_frame_buffer !== 64'd0) begin errors++; $display("FAIL reset_mfb got=%h want=0", memory_frame_buffer); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got=%b want=1", wr_ready); end
        checks++; if (commit_ready !== 1'b1) begin errors++; $display("FAIL reset_commit_ready got=%b want=1", commit_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (swap_pulse !== 1'b0) begin errors++; $display("FAIL reset_swap_pulse got=%b want=0", swap_pulse); end
        checks++; if (frame_done_index !== 6'd63) begin errors++; $display("FAIL reset_fdi got=%0d want=63", frame_done_index); end
        rst_n = 1;
        for (int i = 0; i < 140; i++) begin
            tick();
            checks++;
            if (memory_frame_buffer !== 64'd0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_after_reset cyc=%0d mfb=%h busy=%b wr_ready=%b want 0/0/1", i, memory_frame_buffer, busy, wr_ready);
            end
        end
    endtask

    task automatic test_diagonal();
        bit done = 0;
        hold_frames = 0;
        for (int r = 0; r < 8; r++) write_row(3'(r), 8'(1 << r));
        commit();
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            checks++;
            if (swap_pulse !== m_swap) begin errors++; $display("FAIL diag_swap_pulse cyc=%0d got=%b want=%b", i, swap_pulse, m_swap); end
            checks++;
            if (memory_frame_buffer !== m_out()) begin errors++; $display("FAIL diag_mfb cyc=%0d got=%h want=%h", i, memory_frame_buffer, m_out()); end
            if (m_swap) begin
                done = 1;
                checks++;
                if (memory_frame_buffer !== 64'h8040201008040201) begin errors++; $display("FAIL diag_image got=%h want=8040201008040201", memory_frame_buffer); end
            end
        end
        if (!done) begin checks++; errors++; $display("FAIL diag_timeout no swap within bound"); end
        tick();
        checks++;
        if (swap_pulse !== 1'b0) begin errors++; $display("FAIL diag_pulse_width got=%b want=0", swap_pulse); end
    endtask

    task automatic test_hold();
        logic [63:0] old_img;
        int strobes = 0;
        bit done = 0;
        old_img = m_out();
        hold_frames = 3;
        write_row(3'd0, 8'hA5);
        write_row(3'd7, 8'h3C);
        commit();
        for (int i = 0; i < 400 && !done; i++) begin
            tick();
            if (last_fd) strobes++;
            if (m_swap) begin
                done = 1;
                checks++;
                if (strobes !== 4) begin errors++; $display("FAIL hold_strobe_count got=%0d want=4", strobes); end
                checks++;
                if (swap_pulse !== 1'b1 || memory_frame_buffer !== m_out()) begin
                    errors++; $display("FAIL hold_swap pulse=%b mfb=%h want 1/%h", swap_pulse, memory_frame_buffer, m_out());
                end
            end else begin
                checks++;
                if (busy !== 1'b1 || wr_ready !== 1'b0 || memory_frame_buffer !== old_img) begin
                    errors++; $display("FAIL hold_pending cyc=%0d busy=%b wr_ready=%b mfb=%h want 1/0/%h", i, busy, wr_ready, memory_frame_buffer, old_img);
                end
            end
        end
        if (!done) begin checks++; errors++; $display("FAIL hold_timeout no swap within bound"); end
    endtask

    task automatic test_same_cycle();
        bit done = 0;
        hold_frames = 0;
        wr_valid = 1; wr_row = 3'd5; wr_data = 8'hFF; commit_valid = 1;
        tick();
        commit_valid = 0;
        wr_row = 3'd2; wr_data = 8'hAA;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            checks++;
            if (wr_ready !== !m_pend) begin errors++; $display("FAIL stall_wr_ready cyc=%0d got=%b want=%b", i, wr_ready, !m_pend); end
            if (m_swap) begin
                done = 1;
                checks++;
                if (memory_frame_buffer[47:40] !== 8'hFF) begin errors++; $display("FAIL same_cycle_row5 got=%h want=ff", memory_frame_buffer[47:40]); end
                checks++;
                if (swap_pulse !== 1'b1 || wr_ready !== 1'b1) begin errors++; $display("FAIL resume pulse=%b wr_ready=%b want 1/1", swap_pulse, wr_ready); end
            end
        end
        if (!done) begin checks++; errors++; $display("FAIL same_cycle_timeout no swap within bound"); end
        tick();
        wr_valid = 0;
        commit();
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            if (m_swap) begin
                done = 1;
                checks++;
                if (memory_frame_buffer[23:16] !== 8'hAA) begin errors++; $display("FAIL held_write_row2 got=%h want=aa", memory_frame_buffer[23:16]); end
            end
        end
        if (!done) begin checks++; errors++; $display("FAIL held_write_timeout no swap within bound"); end
    endtask

    task automatic test_blank();
        bit done = 0;
        blank = 1;
        tick();
        checks++;
        if (memory_frame_buffer !== 64'd0 || m_front === 64'd0) begin errors++; $display("FAIL blank_out got=%h want=0 (front=%h)", memory_frame_buffer, m_front); end
        hold_frames = 1;
        write_row(3'd3, 8'h5A);
        commit();
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            checks++;
            if (swap_pulse !== m_swap || memory_frame_buffer !== 64'd0) begin
                errors++; $display("FAIL blank_pending cyc=%0d pulse=%b mfb=%h want %b/0", i, swap_pulse, memory_frame_buffer, m_swap);
            end
            if (m_swap) done = 1;
        end
        if (!done) begin checks++; errors++; $display("FAIL blank_timeout no swap within bound"); end
        blank = 0;
        tick();
        checks++;
        if (memory_frame_buffer !== m_front || memory_frame_buffer[31:24] !== 8'h5A) begin
            errors++; $display("FAIL unblank got=%h want=%h", memory_frame_buffer, m_front);
        end
    endtask

    task automatic test_reset_pending();
        hold_frames = 0;
        write_row(3'd1, 8'hC3);
        commit();
        while (last_fd !== 1'b0 || is_frame_done !== 1'b0) tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rp_busy_before got=%b want=1", busy); end
        rst_n = 0;
        #1;
        model_clear();
        checks++;
        if (busy !== 1'b0 || swap_pulse !== 1'b0 || memory_frame_buffer !== 64'd0) begin
            errors++; $display("FAIL rp_async busy=%b pulse=%b mfb=%h want 0/0/0", busy, swap_pulse, memory_frame_buffer);
        end
        tick();
        rst_n = 1;
        for (int i = 0; i < 140; i++) begin
            tick();
            checks++;
            if (swap_pulse !== 1'b0 || memory_frame_buffer !== 64'd0 || busy !== 1'b0) begin
                errors++; $display("FAIL rp_no_swap cyc=%0d pulse=%b mfb=%h busy=%b want 0/0/0", i, swap_pulse, memory_frame_buffer, busy);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            wr_valid     = ($urandom_range(0, 2) == 0);
            wr_row       = 3'($urandom_range(0, 7));
            wr_data      = 8'($urandom);
            commit_valid = ($urandom_range(0, 9) == 0);
            blank        = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) hold_frames = 4'($urandom_range(0, 2));
            tick();
            checks++;
            if (memory_frame_buffer !== m_out() || swap_pulse !== m_swap || busy !== m_pend ||
                wr_ready !== !m_pend || commit_ready !== !m_pend) begin
                errors++;
                $display("FAIL random cyc=%0d mfb=%h pulse=%b busy=%b wr_rdy=%b cm_rdy=%b want %h/%b/%b/%b/%b",
                         i, memory_frame_buffer, swap_pulse, busy, wr_ready, commit_ready,
                         m_out(), m_swap, m_pend, !m_pend, !m_pend);
            end
        end
        wr_valid = 0; commit_valid = 0; blank = 0;
    endtask

    initial begin
        rst_n = 1; wr_valid = 0; wr_row = 0; wr_data = 0; commit_valid = 0;
        hold_frames = 0; blank = 0; is_frame_done = 0; phase = 0; last_fd = 0;
        model_clear();
        test_reset();
        test_diagonal();
        test_hold();
        test_same_cycle();
        test_blank();
        test_reset_pending();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Double-buffered frame controller for the 8x8 charlieplex LED scanner. A host writes rows into a back buffer through a valid/ready port, then requests a commit. The swap to the front buffer happens only at a scan-frame boundary, and only after a programmable minimum number of scan frames, so images never tear and animation pacing is enforced. The block drives the scanner's 64-bit frame buffer and frame-done index inputs and consumes its `is_frame_done` strobe.

## Interface
Parameters:
- `FRAME_DONE_INDEX`, default 6'd63: scan index at which the scanner reports frame done; driven unchanged on `frame_done_index`.
- `HOLD_W`, default 4: width of the hold-frame counter and `hold_frames`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wr_valid`  in  1  row write request.
- `wr_ready`  out  1  row write accepted when `wr_valid & wr_ready`.
- `wr_row`  in  3  target row, 0..7.
- `wr_data`  in  8  row data; bit c = LED at column c.
- `commit_valid`  in  1  request back-to-front swap.
- `commit_ready`  out  1  commit accepted when `commit_valid & commit_ready`.
- `hold_frames`  in  HOLD_W  minimum scan frames the current image is displayed before a swap.
- `blank`  in  1  forces the displayed frame to all zeros.
- `is_frame_done`  in  1  one-cycle strobe from the scanner, once per 64 clocks.
- `memory_frame_buffer`  out  64  front buffer to the scanner; row r = bits [8r+7:8r].
- `frame_done_index`  out  6  constant `FRAME_DONE_INDEX`.
- `swap_pulse`  out  1  one-cycle pulse, the cycle after a swap.
- `busy`  out  1  high while a commit is pending.

## Operation
- Storage: two 64-bit buffers, A and B, plus a `front_sel` bit. Front = A when `front_sel`=0, otherwise B. Back = the other buffer.
- States:
  - IDLE: `wr_ready`=1, `commit_ready`=1, `busy`=0.
  - PENDING: `wr_ready`=0, `commit_ready`=0, `busy`=1.
- Write: an accepted write stores `wr_data` into back buffer bits [8*wr_row+7 : 8*wr_row]. All other bits are unchanged.
- Commit: an accepted commit moves IDLE -> PENDING.
- Simultaneous write and commit in IDLE: both are accepted, and the write is included in the committed frame.
- Swap condition: in PENDING, when `is_frame_done`=1 and `hold_cnt >= hold_frames`:
  - toggle `front_sel`;
  - set `hold_cnt` to 0;
  - move to IDLE.
  The new back buffer holds the previous front image. It is not cleared and not copied.
- `hold_cnt` (HOLD_W bits):
  - increments on each `is_frame_done` that does not cause a swap, in either state;
  - saturates at all-ones.
- `hold_frames`=0: the swap occurs at the first `is_frame_done` after the commit.
- `hold_frames` is sampled live on every `is_frame_done`; changing it mid-pend takes effect at the next frame boundary.
- `blank` is registered (`blank_q`). `memory_frame_buffer = blank_q ? 64'b0 : front`, computed combinationally from the registered front buffer and `front_sel`.
- `blank` does not affect writes, commits or swaps.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - both buffers = 0, `front_sel`=0, state IDLE, `hold_cnt`=0, `blank_q`=0;
  - resulting outputs: `swap_pulse`=0, `busy`=0, `wr_ready`=1, `commit_ready`=1, `memory_frame_buffer`=0, `frame_done_index`=`FRAME_DONE_INDEX`.
- Reset mid-PENDING: the commit is discarded, and buffer contents return to zero.
- Write latency: data is in the back buffer at the accepting edge. It is visible on `memory_frame_buffer` only after a swap.
- Swap edge: the edge at which `is_frame_done`=1 and the swap condition holds.
  - `memory_frame_buffer` shows the new image in the cycle immediately after that edge, so the scanner's next index 0 sees it.
  - `swap_pulse`=1 in that same cycle only.
- A commit accepted on an `is_frame_done` cycle cannot swap at that edge. The earliest swap is the next frame boundary.
- `blank` latency: 1 cycle.
- `wr_ready`, `commit_ready` and `busy` are decoded from state (no extra latency). Requests presented during PENDING stall until the cycle after the swap.

## Test plan
- After reset, with `is_frame_done` strobing every 64 cycles: `memory_frame_buffer`=0, `wr_ready`=1, `busy`=0.
- Write rows 0..7 = 8'h01,02,04,08,10,20,40,80, commit with `hold_frames`=0: swap at the next strobe; `memory_frame_buffer`=64'h8040201008040201 and `swap_pulse`=1 for one cycle, both the cycle after the swap edge.
- `hold_frames`=3, second image committed immediately after the first swap: `busy`=1 and `wr_ready`=0 through 3 strobes; swap at the 4th strobe; the old image stays displayed until then.
- Write and commit in the same cycle (row 5 = 8'hFF): the committed frame includes row 5 = FF. A write held during PENDING is accepted the cycle after `swap_pulse`.
- Assert `blank` with a nonzero front buffer: output is 0 one cycle later. A pending commit still swaps on schedule; deasserting `blank` shows the new image.
- Drop `rst_n` while PENDING: `busy`, `swap_pulse` and `memory_frame_buffer` go to 0 immediately, and no swap occurs at later strobes.
